joystick_dir_decoder: RTL
=========================

Name: joystick_dir_decoder

Overview:
Consumes the joystick reader's per-axis 10-bit ADC results (analog_x/analog_y, qualified by its data_ready pulse) in the 4 MHz domain. Box-car averages each axis and classifies it against a centre deadzone with hysteresis. Debounces the resulting direction over consecutive windows and drives registered up/down/left/right levels plus a change pulse for downstream game/UI logic.

Parameters:
CENTER, 512, axis rest code.
DEADZONE, 64, distance from CENTER at which an axis becomes active.
HYST, 16, release margin inside the deadzone edge.
AVG_LOG2, 2, log2 of samples per averaging window; 0 means no averaging.
HOLD_COUNT, 3, consecutive identical classified windows required to commit a new direction; range 1..15.

Ports:
clk  in  1  system clock, 4 MHz joystick domain.
rst_n  in  1  asynchronous active-low reset.
sample_valid  in  1  one-cycle strobe; analog_x/analog_y are valid when high. Connect to data_ready.
analog_x  in  10  X-axis ADC code.
analog_y  in  10  Y-axis ADC code.
x_filt  out  10  averaged X, held between windows.
y_filt  out  10  averaged Y, held between windows.
filt_valid  out  1  one-cycle pulse when x_filt/y_filt update.
dir_up  out  1  committed Y positive.
dir_down  out  1  committed Y negative.
dir_left  out  1  committed X negative.
dir_right  out  1  committed X positive.
dir_change  out  1  one-cycle pulse when any dir_* output changes.

Behaviour:
- Reset: all outputs 0; accumulators, sample counter, debounce counter and candidate cleared; committed state NEU/NEU.
- Elaboration check, fatal on violation: CENTER+DEADZONE<=1023, CENTER>=DEADZONE, HYST<DEADZONE, 1<=HOLD_COUNT<=15.
- Averaging:
  - Per-axis accumulator is 10+AVG_LOG2 bits, unsigned, so it cannot overflow.
  - Every sample_valid adds one sample; there is no backpressure and strobes on consecutive cycles are all accepted.
  - On the 2^AVG_LOG2-th sample of a window, the next cycle loads filt = sum>>AVG_LOG2 (floor) and pulses filt_valid. The accumulator restarts with no gap.
  - Latency: 1 cycle from the last strobe of a window.
- Per-axis classifier, 3 states NEG/NEU/POS, evaluated on the filt_valid cycle and registered:
  - NEU to POS if filt>=CENTER+DEADZONE.
  - NEU to NEG if filt<=CENTER-DEADZONE.
  - POS to NEU if filt<CENTER+DEADZONE-HYST.
  - NEG to NEU if filt>CENTER-DEADZONE+HYST.
  - POS/NEG may jump directly to the opposite state if the opposite entry threshold is met.
- Debounce on the joint pair {x_state, y_state}, evaluated the cycle after classification:
  - Raw pair equals committed pair: counter cleared.
  - Raw pair differs from committed and equals candidate: counter +1.
  - Raw pair differs from committed and differs from candidate: candidate = raw, counter = 1.
  - Commit when the counter reaches HOLD_COUNT; the counter then clears.
  - HOLD_COUNT=1 commits on the first differing window.
- Outputs:
  - dir_right = X POS; dir_left = X NEG; dir_up = Y POS; dir_down = Y NEG. Diagonals assert two outputs.
  - dir_* and dir_change are registered together. dir_change pulses exactly once per commit.
  - End-to-end: window's last strobe at cycle n, then filt at n+1, class at n+2, dir_*/dir_change at n+3.
- rst_n asserted mid-window discards the partial sum and the in-flight pipeline. The first post-reset window starts at the first strobe.

Test Plan:
- Reset, then no strobes for 100 cycles -> all outputs 0, no filt_valid or dir_change pulses.
- Averaging: X strobes 100,200,300,400 -> x_filt=250 with one filt_valid pulse 1 cycle after the 4th strobe. Next window 1,1,1,2 -> x_filt=1 (floor).
- Commit: x=600, y=512 for 12 strobes -> dir_right=1 and one dir_change pulse 3 cycles after the 12th strobe. No change after windows 1-2.
- Hysteresis: right committed, x=565 for 3 windows -> stays right. Then x=555 for 3 windows -> dir_right=0 with one dir_change pulse.
- Glitch rejection: neutral committed; window averages 600,600,512,600,600,600 -> commit only after the 6th window. Diagonal x=1023, y=0 -> dir_right=dir_down=1 with a single dir_change.
- Reset mid-window: 2 strobes of 900, pulse rst_n low asynchronously (not clock-aligned), then 4 strobes of 100 -> x_filt=100 and dir_* remain 0.

Source files
------------

// File: rtl/joystick_dir_decoder.sv
// joystick_dir_decoder
// Averages the joystick ADC axes over fixed windows, classifies each averaged
// axis against a centre deadzone with release hysteresis, debounces the joint
// direction over consecutive windows and drives registered direction levels
// plus a one-cycle change pulse.
//
// Pipeline, counted from the cycle n that carries the last strobe of a window:
//   n+1 : x_filt/y_filt updated, filt_valid pulse
//   n+2 : per-axis class registered
//   n+3 : dir_* and dir_change registered
module joystick_dir_decoder #(
    parameter int unsigned CENTER     = 512,
    parameter int unsigned DEADZONE   = 64,
    parameter int unsigned HYST       = 16,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned HOLD_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [9:0] analog_x,
    input  logic [9:0] analog_y,
    output logic [9:0] x_filt,
    output logic [9:0] y_filt,
    output logic       filt_valid,
    output logic       dir_up,
    output logic       dir_down,
    output logic       dir_left,
    output logic       dir_right,
    output logic       dir_change
);

    // ------------------------------------------------------------------
    // Widths and thresholds
    // ------------------------------------------------------------------
    localparam int unsigned ADC_W    = 10;
    localparam int unsigned ACC_W    = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned NSAMP_M1 = (1 << AVG_LOG2) - 1;
    localparam int unsigned HOLD_W   = 4;

    // Entry thresholds (inclusive) and release thresholds (strict)
    localparam int unsigned POS_ON   = CENTER + DEADZONE;
    localparam int unsigned NEG_ON   = CENTER - DEADZONE;
    localparam int unsigned POS_OFF  = CENTER + DEADZONE - HYST;
    localparam int unsigned NEG_OFF  = CENTER - DEADZONE + HYST;

    // Reject parameter sets that would wrap thresholds or overflow the hold counter
    generate
        if ((CENTER + DEADZONE > 1023) || (CENTER < DEADZONE) ||
            (HYST >= DEADZONE) || (HOLD_COUNT < 1) || (HOLD_COUNT > 15)) begin : g_bad_params
            $fatal(1, "joystick_dir_decoder: illegal parameter set");
        end
    endgenerate

    // Per-axis classification state
    typedef enum logic [1:0] {
        AX_NEU = 2'd0,
        AX_POS = 2'd1,
        AX_NEG = 2'd2
    } axis_t;

    // ------------------------------------------------------------------
    // Box-car averaging
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc_x;
    logic [ACC_W-1:0] r_acc_y;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum_x;
    logic [ACC_W-1:0] w_sum_y;
    logic             w_last;

    // Running sums including the current strobe; detect the window's final sample
    always_comb begin
        w_sum_x = r_acc_x + ACC_W'(analog_x);
        w_sum_y = r_acc_y + ACC_W'(analog_y);
        w_last  = (AVG_LOG2 == 0) || (r_cnt == CNT_W'(NSAMP_M1));
    end

    // Accumulate strobes; on the last one publish the floored mean and restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_cnt      <= '0;
            x_filt     <= '0;
            y_filt     <= '0;
            filt_valid <= 1'b0;
        end else begin
            filt_valid <= 1'b0;
            if (sample_valid) begin
                if (w_last) begin
                    r_acc_x    <= '0;
                    r_acc_y    <= '0;
                    r_cnt      <= '0;
                    x_filt     <= ADC_W'(w_sum_x >> AVG_LOG2);
                    y_filt     <= ADC_W'(w_sum_y >> AVG_LOG2);
                    filt_valid <= 1'b1;
                end else begin
                    r_acc_x <= w_sum_x;
                    r_acc_y <= w_sum_y;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-axis hysteretic classifier (two-process FSM per axis)
    // ------------------------------------------------------------------
    axis_t r_x_state;
    axis_t r_y_state;
    axis_t w_x_next;
    axis_t w_y_next;
    logic  r_cls_valid;

    // Next class of one axis given its current class and a fresh average
    function automatic axis_t f_classify(input axis_t cur, input logic [ADC_W-1:0] filt);
        logic [31:0] v;
        axis_t       nxt;
        v   = 32'(filt);
        nxt = cur;
        case (cur)
            AX_NEU: begin
                if (v >= POS_ON) begin
                    nxt = AX_POS;
                end else if (v <= NEG_ON) begin
                    nxt = AX_NEG;
                end
            end
            AX_POS: begin
                if (v <= NEG_ON) begin
                    nxt = AX_NEG;
                end else if (v < POS_OFF) begin
                    nxt = AX_NEU;
                end
            end
            AX_NEG: begin
                if (v >= POS_ON) begin
                    nxt = AX_POS;
                end else if (v > NEG_OFF) begin
                    nxt = AX_NEU;
                end
            end
            default: nxt = AX_NEU;
        endcase
        return nxt;
    endfunction

    // Classifier next state, evaluated only on the filt_valid cycle
    always_comb begin
        w_x_next = r_x_state;
        w_y_next = r_y_state;
        if (filt_valid) begin
            w_x_next = f_classify(r_x_state, x_filt);
            w_y_next = f_classify(r_y_state, y_filt);
        end
    end

    // Classifier state registers; r_cls_valid marks a freshly classified window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_state   <= AX_NEU;
            r_y_state   <= AX_NEU;
            r_cls_valid <= 1'b0;
        end else begin
            r_x_state   <= w_x_next;
            r_y_state   <= w_y_next;
            r_cls_valid <= filt_valid;
        end
    end

    // ------------------------------------------------------------------
    // Joint-direction debounce and commit
    // ------------------------------------------------------------------
    axis_t             r_com_x;
    axis_t             r_com_y;
    logic [3:0]        r_cand;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [3:0]        w_raw;
    logic [3:0]        w_com;
    logic [3:0]        w_cand_nxt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic              w_commit;

    // Track how many consecutive windows agreed on a direction other than the committed one
    always_comb begin
        w_raw      = {r_x_state, r_y_state};
        w_com      = {r_com_x, r_com_y};
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_hold_cnt;
        w_commit   = 1'b0;
        if (r_cls_valid) begin
            if (w_raw == w_com) begin
                w_cnt_nxt = '0;
            end else begin
                if (w_raw == r_cand) begin
                    w_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end else begin
                    w_cand_nxt = w_raw;
                    w_cnt_nxt  = HOLD_W'(1);
                end
                if (w_cnt_nxt == HOLD_W'(HOLD_COUNT)) begin
                    w_commit  = 1'b1;
                    w_cnt_nxt = '0;
                end
            end
        end
    end

    // Candidate/counter registers; committed pair and direction outputs update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= {AX_NEU, AX_NEU};
            r_hold_cnt <= '0;
            r_com_x    <= AX_NEU;
            r_com_y    <= AX_NEU;
            dir_up     <= 1'b0;
            dir_down   <= 1'b0;
            dir_left   <= 1'b0;
            dir_right  <= 1'b0;
            dir_change <= 1'b0;
        end else begin
            r_cand     <= w_cand_nxt;
            r_hold_cnt <= w_cnt_nxt;
            dir_change <= w_commit;
            if (w_commit) begin
                r_com_x   <= r_x_state;
                r_com_y   <= r_y_state;
                dir_right <= (r_x_state == AX_POS);
                dir_left  <= (r_x_state == AX_NEG);
                dir_up    <= (r_y_state == AX_POS);
                dir_down  <= (r_y_state == AX_NEG);
            end
        end
    end

endmodule
